sum_arbiter: RTL

//  Shares one combinational 8-bit adder (ports a, b -> c, c = a + b mod 2^8) between
//  N_REQ requesters. Round-robin arbitration over valid/ready request channels; single

---
 rtl/sum_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sum_arbiter.sv
// Round-robin front end that time-shares one external DW-bit adder among N_REQ
// valid/ready requesters and returns each result tagged with its requester index.
module sum_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int IDW   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    output logic [DW-1:0]       sum_a,
    output logic [DW-1:0]       sum_b,
    input  logic [DW-1:0]       sum_c,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DW-1:0]       rsp_data,
    output logic [IDW-1:0]      rsp_id,
    output logic                busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]     r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic [DW-1:0]  r_op_a;
    logic [DW-1:0]  r_op_b;
    logic [DW-1:0]  r_rsp_data;
    logic [IDW-1:0] r_rsp_id;
    logic           r_rsp_valid;

    logic           w_any;
    int             w_scan;
    logic [IDW-1:0] w_gnt;
    logic           w_accept;
    logic [DW-1:0]  w_gnt_a;
    logic [DW-1:0]  w_gnt_b;
    logic [IDW-1:0] w_next_ptr;

    // First valid requester at or after r_ptr, wrapping; the offset-0 slot wins ties.
    always_comb begin
        w_any  = 1'b0;
        w_scan = 0;
        w_gnt  = r_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = (int'(r_ptr) + k) % N_REQ;
            if (!w_any && req_valid[w_scan]) begin
                w_any = 1'b1;
                w_gnt = IDW'(w_scan);
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_any && !rst;
    assign w_gnt_a  = req_a[int'(w_gnt)*DW +: DW];
    assign w_gnt_b  = req_b[int'(w_gnt)*DW +: DW];

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = w_accept && (w_gnt == IDW'(i));
        end
    end

    // The requester just served drops to lowest priority for the next search.
    assign w_next_ptr = (r_id == IDW'(N_REQ - 1)) ? '0 : r_id + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_a  <= w_gnt_a;
                        r_op_b  <= w_gnt_b;
                        r_id    <= w_gnt;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_rsp_data  <= sum_c;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= w_next_ptr;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Adder inputs come straight from the operand registers so they hold quietly between jobs.
    assign sum_a     = r_op_a;
    assign sum_b     = r_op_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != S_IDLE);

endmodule
